// File: rtl/console_textbuf_ctrl_pkg.sv
// Shared constants, clear-FSM encoding and cell addressing for the console text buffer.
package console_textbuf_ctrl_pkg;

  localparam int unsigned COLS_DEFAULT = 80;
  localparam int unsigned ROWS_DEFAULT = 30;
  localparam int unsigned RAM_ADDR_W   = 12;

  localparam logic [7:0] BLANK_CHAR   = 8'h20;
  localparam logic [7:0] DEFAULT_ATTR = 8'h07;

  typedef enum logic {
    StIdle,
    StClear
  } clr_state_e;

  function automatic logic [RAM_ADDR_W-1:0] cell_addr(input logic [5:0] row,
                                                      input logic [6:0] col,
                                                      input int unsigned cols);
    int unsigned a;
    a = 32'(row) * cols + 32'(col);
    return a[RAM_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/console_textbuf_ctrl_if.sv
// Host write and clear-request port of the console text buffer.
interface console_textbuf_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [6:0] wr_col;
  logic [4:0] wr_row;
  logic [7:0] wr_char;
  logic [7:0] wr_attr;
  logic       clr_req;
  logic [7:0] clr_attr;
  logic       clr_busy;

  modport master (
    output wr_valid, wr_col, wr_row, wr_char, wr_attr, clr_req, clr_attr,
    input  wr_ready, clr_busy
  );

  modport slave (
    input  wr_valid, wr_col, wr_row, wr_char, wr_attr, clr_req, clr_attr,
    output wr_ready, clr_busy
  );
endinterface

// File: rtl/console_textbuf_ctrl_text_ram.sv
// console_text_ram: single-port 16-bit RAM, synchronous read with one cycle of latency.
module console_text_ram #(
    parameter int unsigned Depth = 2400,
    parameter int unsigned AddrW = 12
) (
    input  logic             CLK_PIXEL,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [15:0]      wdata_i,
    output logic [15:0]      rdata_o
);

    logic [15:0] mem_q [Depth];
    logic [15:0] rdata_q;

    always_ff @(posedge CLK_PIXEL) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/console_textbuf_ctrl.sv
// Console text buffer: display scan-out with priority, host cell writes and an optional
// bulk clear engine enabled by CONSOLE_TEXTBUF_CLEAR_EN.
module console_textbuf_ctrl
    import console_textbuf_ctrl_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEFAULT,
    parameter int unsigned ROWS = ROWS_DEFAULT
) (
    input  logic                  CLK_PIXEL,
    input  logic                  RESET_N,
    input  logic [9:0]            cx,
    input  logic [9:0]            cy,
    output logic [7:0]            character,
    output logic [7:0]            attribute,
    console_textbuf_ctrl_if.slave host
);

    logic                  in_text;
    logic                  slot;
    logic [RAM_ADDR_W-1:0] disp_addr;
    logic [RAM_ADDR_W-1:0] wr_addr;
    logic                  host_we;
    logic                  busy;
    logic                  clr_we;
    logic [RAM_ADDR_W-1:0] clr_addr;
    logic [7:0]            clr_fill_attr;
    logic                  ram_we;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [15:0]           ram_wdata;
    logic [15:0]           ram_rdata;

    assign in_text   = (32'(cx) < COLS * 32'd8) && (32'(cy) < ROWS * 32'd16);
    assign slot      = in_text && (cx[2:0] == 3'd0);
    assign disp_addr = cell_addr(cy[9:4], cx[9:3], COLS);
    assign wr_addr   = cell_addr({1'b0, host.wr_row}, host.wr_col, COLS);

    assign host.wr_ready = RESET_N & ~busy & ~slot;
    // Out-of-range writes still complete the handshake but never reach the RAM.
    assign host_we = host.wr_valid & host.wr_ready
                   & (32'(host.wr_col) < COLS) & (32'(host.wr_row) < ROWS);

`ifdef CONSOLE_TEXTBUF_CLEAR_EN
    localparam logic [RAM_ADDR_W-1:0] LastAddr = RAM_ADDR_W'(COLS * ROWS - 1);

    clr_state_e            state_q, state_d;
    logic [RAM_ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]            attr_q, attr_d;
    logic                  init_q, init_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        attr_d  = attr_q;
        init_d  = init_q;
        clr_we  = 1'b0;
        case (state_q)
            StIdle: begin
                // The pending post-reset clear takes precedence over a host request.
                if (init_q) begin
                    state_d = StClear;
                    addr_d  = '0;
                    attr_d  = DEFAULT_ATTR;
                    init_d  = 1'b0;
                end else if (host.clr_req) begin
                    state_d = StClear;
                    addr_d  = '0;
                    attr_d  = host.clr_attr;
                end
            end
            StClear: begin
                if (!slot) begin
                    clr_we = 1'b1;
                    addr_d = addr_q + 1'b1;
                    if (addr_q == LastAddr) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK_PIXEL) begin
        if (!RESET_N) begin
            state_q <= StIdle;
            addr_q  <= '0;
            attr_q  <= '0;
            init_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            attr_q  <= attr_d;
            init_q  <= init_d;
        end
    end

    assign busy          = (state_q == StClear);
    assign clr_addr      = addr_q;
    assign clr_fill_attr = attr_q;
`else
    logic unused_clr;
    assign unused_clr    = ^{host.clr_req, host.clr_attr};
    assign busy          = 1'b0;
    assign clr_we        = 1'b0;
    assign clr_addr      = '0;
    assign clr_fill_attr = '0;
`endif

    assign host.clr_busy = busy;

    // RESET_N gates writes so an interrupted clear stops on the very cycle reset asserts.
    assign ram_we    = RESET_N & ~slot & (clr_we | host_we);
    assign ram_addr  = slot ? disp_addr : (clr_we ? clr_addr : wr_addr);
    assign ram_wdata = clr_we ? {clr_fill_attr, BLANK_CHAR} : {host.wr_attr, host.wr_char};

    console_text_ram #(
        .Depth(COLS * ROWS),
        .AddrW(RAM_ADDR_W)
    ) u_ram (
        .CLK_PIXEL(CLK_PIXEL),
        .we_i     (ram_we),
        .addr_i   (ram_addr),
        .wdata_i  (ram_wdata),
        .rdata_o  (ram_rdata)
    );

    logic       slot_q;
    logic       blank_q;
    logic [7:0] char_q;
    logic [7:0] attr_out_q;

    always_ff @(posedge CLK_PIXEL) begin
        if (!RESET_N) begin
            slot_q     <= 1'b0;
            blank_q    <= 1'b0;
            char_q     <= 8'h00;
            attr_out_q <= 8'h00;
        end else begin
            slot_q  <= slot;
            blank_q <= ~in_text;
            if (slot_q) begin
                char_q     <= ram_rdata[7:0];
                attr_out_q <= ram_rdata[15:8];
            end else if (blank_q) begin
                char_q     <= BLANK_CHAR;
                attr_out_q <= 8'h00;
            end
        end
    end

    assign character = char_q;
    assign attribute = attr_out_q;

endmodule

// File: tb/tb_console_textbuf_ctrl.sv
// Scoreboard bench for console_textbuf_ctrl; clear tests run when CONSOLE_TEXTBUF_CLEAR_EN is set.
module tb_console_textbuf_ctrl;

    logic       CLK_PIXEL = 1'b0;
    logic       RESET_N;
    logic [9:0] cx, cy;
    logic [7:0] character, attribute;

    always #5 CLK_PIXEL = ~CLK_PIXEL;

    console_textbuf_ctrl_if bus ();

    console_textbuf_ctrl #(
        .COLS(80),
        .ROWS(30)
    ) dut (
        .CLK_PIXEL(CLK_PIXEL),
        .RESET_N  (RESET_N),
        .cx       (cx),
        .cy       (cy),
        .character(character),
        .attribute(attribute),
        .host     (bus)
    );

    // kind 0: {character, attribute}; kind 1: wr_ready; kind 2: clr_busy
    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge CLK_PIXEL) cyc <= cyc + 1;

    always @(negedge CLK_PIXEL) begin
        exp_t        e;
        logic [15:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.cyc < cyc) begin
                bad++;
                $display("FAIL %s: check for cycle %0d missed at cycle %0d", e.name, e.cyc, cyc);
            end else begin
                case (e.kind)
                    0:       act = {character, attribute};
                    1:       act = {15'd0, bus.wr_ready};
                    default: act = {15'd0, bus.clr_busy};
                endcase
                if (act !== e.val) begin
                    bad++;
                    $display("FAIL %s @%0d: got %h want %h", e.name, cyc, act, e.val);
                end
            end
        end
    end

    function automatic void push(int at, int kind, logic [15:0] val, string name);
        exp_t e;
        int   i;
        e.cyc  = at;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > at) i--;
        sb.insert(i, e);
    endfunction

    task automatic tick();
        @(posedge CLK_PIXEL);
        #1;
    endtask

    task automatic park();
        cx = 10'd700;
        cy = 10'd500;
    endtask

    // Coordinates must be outside the text area so the write is accepted immediately.
    task automatic host_write(int col, int row, int ch, int at);
        bus.wr_valid = 1'b1;
        bus.wr_col   = 7'(col);
        bus.wr_row   = 5'(row);
        bus.wr_char  = 8'(ch);
        bus.wr_attr  = 8'(at);
        push(cyc, 1, 16'd1, "wr_accept");
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic read_cell(int col, int row, logic [15:0] expv, string name);
        cx = 10'(col * 8);
        cy = 10'(row * 16);
        push(cyc + 2, 0, expv, name);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, j, r;
        RESET_N      = 1'b0;
        park();
        bus.wr_valid = 1'b0;
        bus.wr_col   = '0;
        bus.wr_row   = '0;
        bus.wr_char  = '0;
        bus.wr_attr  = '0;
        bus.clr_req  = 1'b0;
        bus.clr_attr = '0;

        tick();
        tick();
        push(cyc, 0, 16'h0000, "rst_out");
        push(cyc, 1, 16'd0, "rst_ready");
        push(cyc, 2, 16'd0, "rst_busy");
        tick();
        tick();

        RESET_N = 1'b1;
        k = cyc;
        push(k, 1, 16'd1, "release_ready");
        push(k, 2, 16'd0, "release_busy");
`ifdef CONSOLE_TEXTBUF_CLEAR_EN
        push(k + 1, 2, 16'd1, "autoclr_start");
        push(k + 1, 1, 16'd0, "autoclr_ready");
        push(k + 2400, 2, 16'd1, "autoclr_last");
        push(k + 2401, 2, 16'd0, "autoclr_done");
        repeat (2402) tick();
`else
        tick();
`endif

        // Cell write then scan of its slot, held across the 8-pixel cell.
        host_write(3, 2, 'h41, 'h1F);
        k = cyc;
        for (int i = 0; i < 8; i++) push(k + 2 + i, 0, 16'h411F, "scan_hold");
        for (int i = 0; i < 8; i++) begin
            cx = 10'(24 + i);
            cy = 10'd32;
            tick();
        end
        park();
        push(cyc + 2, 0, 16'h2000, "blank_after_scan");
        tick();

        // Outside text area: right of it, then below it.
        read_cell(3, 2, 16'h411F, "reread");
        cx = 10'd640;
        cy = 10'd100;
        push(cyc + 2, 0, 16'h2000, "blank_cx640");
        tick();
        read_cell(3, 2, 16'h411F, "reread2");
        cx = 10'd0;
        cy = 10'd480;
        push(cyc + 2, 0, 16'h2000, "blank_cy480");
        tick();
        park();
        tick();

        // Host write stalled by a display slot at cx=8.
        cy = 10'd0;
        cx = 10'd7;
        bus.wr_valid = 1'b1;
        bus.wr_col = 7'd5; bus.wr_row = 5'd0; bus.wr_char = 8'h42; bus.wr_attr = 8'h2A;
        push(cyc, 1, 16'd1, "ready_cx7");
        tick();
        cx = 10'd8;
        bus.wr_col = 7'd6; bus.wr_char = 8'h43; bus.wr_attr = 8'h3B;
        push(cyc, 1, 16'd0, "ready_cx8_slot");
        tick();
        cx = 10'd9;
        push(cyc, 1, 16'd1, "ready_cx9");
        tick();
        bus.wr_valid = 1'b0;
        park();
        tick();
        read_cell(5, 0, 16'h422A, "cell_5_0");
        read_cell(6, 0, 16'h433B, "cell_6_0");
        park();
        tick();

        // Out-of-range writes must not alias onto neighbouring cells.
        host_write(79, 0, 'h58, 'h11);
        host_write(0, 1, 'h59, 'h22);
        host_write(80, 0, 'hFF, 'hFF);
        host_write(0, 30, 'hFF, 'hFF);
        read_cell(79, 0, 16'h5811, "cell_79_0");
        read_cell(0, 1, 16'h5922, "cell_0_1");
        park();

        // Write followed immediately by a display read of the same cell.
        host_write(10, 5, 'h61, 'h07);
        read_cell(10, 5, 16'h6107, "write_then_read");
        park();
        tick();

`ifdef CONSOLE_TEXTBUF_CLEAR_EN
        // Clear request together with an accepted host write; a second request is ignored.
        j = cyc;
        bus.clr_req  = 1'b1;
        bus.clr_attr = 8'h4E;
        bus.wr_valid = 1'b1;
        bus.wr_col = 7'd3; bus.wr_row = 5'd2; bus.wr_char = 8'h77; bus.wr_attr = 8'h77;
        push(j, 1, 16'd1, "clr_with_write_ready");
        push(j + 1, 2, 16'd1, "clr_busy_start");
        push(j + 1, 1, 16'd0, "clr_ready_start");
        push(j + 1200, 1, 16'd0, "clr_ready_mid");
        push(j + 2400, 1, 16'd0, "clr_ready_last");
        push(j + 2400, 2, 16'd1, "clr_busy_last");
        push(j + 2401, 2, 16'd0, "clr_busy_done");
        push(j + 2401, 1, 16'd1, "clr_ready_done");
        tick();
        bus.clr_req  = 1'b0;
        bus.wr_valid = 1'b0;
        repeat (99) tick();
        bus.clr_req  = 1'b1;
        bus.clr_attr = 8'h99;
        tick();
        bus.clr_req  = 1'b0;
        while (cyc < j + 2402) tick();

        for (int row = 0; row < 30; row++) begin
            for (int col = 0; col < 80; col++) read_cell(col, row, 16'h204E, "cleared_cell");
        end
        park();
        repeat (3) tick();

        // Auto-clear after reset, interrupted by reset while addressing cell 1000.
        RESET_N = 1'b0;
        tick();
        tick();
        push(cyc, 2, 16'd0, "rst2_busy");
        tick();
        RESET_N = 1'b1;
        r = cyc;
        push(r + 1, 2, 16'd1, "reclr_busy");
        while (cyc < r + 1001) tick();
        RESET_N = 1'b0;
        push(cyc, 1, 16'd0, "abort_ready");
        push(cyc + 1, 2, 16'd0, "abort_busy");
        push(cyc + 1, 0, 16'h0000, "abort_out");
        repeat (3) tick();
        RESET_N = 1'b1;
        push(cyc + 1, 2, 16'd1, "reclr2_busy");
        read_cell(39, 12, 16'h2007, "cell_999_cleared");
        read_cell(41, 12, 16'h204E, "cell_1001_kept");
        park();
        repeat (3) tick();
`else
        // Without the clear engine, clr_req has no effect.
        bus.clr_req  = 1'b1;
        bus.clr_attr = 8'h4E;
        push(cyc + 1, 2, 16'd0, "noclr_busy");
        push(cyc + 1, 1, 16'd1, "noclr_ready");
        tick();
        bus.clr_req = 1'b0;
        push(cyc + 5, 2, 16'd0, "noclr_busy_later");
        repeat (2) tick();
        read_cell(3, 2, 16'h411F, "noclr_cell_kept");
        park();
        repeat (6) tick();
`endif

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/console_textbuf_ctrl.md
CONSOLE_TEXTBUF_CTRL -- requirements
Module: console_textbuf_ctrl

Interface
REQ-001 Parameter COLS, default 80: text columns (8 px cells).
REQ-002 Parameter ROWS, default 30: text rows (16 px cells).
REQ-003 CLK_PIXEL  in  1  pixel clock; sole clock.
REQ-004 RESET_N  in  1  reset; synchronous and active-low.
REQ-005 cx, cy  in  10 each  current pixel coordinates.
REQ-006 character, attribute  out  8 each  cell byte pair to the console renderer, registered.
REQ-007 wr_valid  in  1; wr_ready  out  1: host write handshake.
REQ-008 wr_col  in  7; wr_row  in  5; wr_char  in  8; wr_attr  in  8: host write payload.
REQ-009 clr_req  in  1  one-cycle clear request; clr_attr  in  8  clear attribute; clr_busy  out  1.

Function
REQ-010 Single-port text RAM, COLS*ROWS words of 16 bits {attr, char}, 12-bit address = row*COLS + col, synchronous read, 1-cycle latency.
REQ-011 Display slot: cycle where cx < COLS*8, cy < ROWS*16 and cx[2:0] == 0; RAM reads address (cy>>4)*COLS + (cx>>3).
REQ-012 Display slot has absolute priority; host and clear never access RAM in a display slot.
REQ-013 character/attribute update exactly 2 cycles after the display-slot cycle and hold until the next update; the integrator delays cx/cy to the renderer by 2 cycles.
REQ-014 Non-slot cycle with cx/cy outside text area: character/attribute load 8'h20/8'h00 on the same 2-cycle pipeline.
REQ-015 wr_ready = RESET_N high, not clr_busy, not a display slot (combinational).
REQ-016 wr_valid & wr_ready writes {wr_attr, wr_char} in that cycle; wr_valid may assert in any cycle and holds payload until accepted.
REQ-017 Accepted write with wr_col >= COLS or wr_row >= ROWS completes the handshake and leaves RAM unchanged.
REQ-018 Write then display read of same cell in the next slot returns new data (no stale bypass needed beyond RAM ordering).
REQ-019 Clear FSM states IDLE, CLEAR: IDLE->CLEAR on clr_req (latch clr_attr, addr=0); CLEAR writes {attr, 8'h20} to addr on each non-display cycle, addr increments; CLEAR->IDLE after writing COLS*ROWS-1.
REQ-020 clr_busy high exactly while state is CLEAR.
REQ-021 clr_req while clr_busy is ignored; clr_req in the same cycle as an accepted host write: write completes, CLEAR begins next cycle.

Reset
REQ-022 While RESET_N low: character=8'h00, attribute=8'h00, wr_ready=0, clr_busy=0, FSM IDLE, pipeline cleared; RAM contents untouched.
REQ-023 Reset asserted mid-clear aborts the clear; partial contents remain.

Configuration
REQ-024 Macro CONSOLE_TEXTBUF_CLEAR_EN defined: clear FSM, clr_req, clr_attr and clr_busy function as above, and the first cycle after reset release enters CLEAR with attribute 8'h07.
REQ-025 Macro undefined: no clear FSM; clr_req/clr_attr ignored, clr_busy tied 0, no auto-clear.

Structure
REQ-026 Shared package holds COLS/ROWS defaults, blank char 8'h20, default attribute 8'h07, RAM address width, FSM state encoding.
REQ-027 One sub-module console_text_ram: single-port synchronous-read 16-bit RAM with write enable.

Verification
REQ-028 Write (col 3,row 2)=char 8'h41 attr 8'h1F, then scan cy=32, cx=24 slot -> character 8'h41, attribute 8'h1F two cycles later, held 8 cycles.
REQ-029 wr_valid held from cx=7 through cx=8 in active area -> wr_ready 0 at cx=8, write accepted at cx=7 only; next request accepted at cx=9.
REQ-030 Write col 80 row 0, data 8'hFF -> handshake completes, cell (79,0) and (0,1) unchanged.
REQ-031 With CLEAR_EN, clr_req with clr_attr 8'h4E -> clr_busy high 2400 write cycles (excluding slots), all cells read 8'h20/8'h4E, wr_ready 0 throughout.
REQ-032 Reset release with CLEAR_EN -> clr_busy asserts next cycle; reset re-asserted at addr 1000 -> clr_busy 0, cell 999 cleared, cell 1001 unchanged.
REQ-033 cx=640, cy=100 -> character 8'h20, attribute 8'h00 two cycles later.
